mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 127 ++++++++++++
 tb/tb_mem_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed 256x16 memory slave with byte-lane enables, two-edge write
// commit, read/write counters and range/conflict flags.
module mem_responder (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [19:0] ADDR,
    input  logic [15:0] Data_in,
    input  logic        Mem_CE,
    input  logic        Mem_UB,
    input  logic        Mem_LB,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    output logic [15:0] Data_out,
    output logic        Data_valid,
    output logic        Range_err,
    output logic        Conflict,
    output logic [7:0]  Rd_count,
    output logic [7:0]  Wr_count
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD      = 2'd1;
    localparam logic [1:0] WR1     = 2'd2;
    localparam logic [1:0] WR_DONE = 2'd3;

    logic [1:0]  state;
    logic [15:0] mem [256];

    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ub;
    logic        wr_lb;
    logic        wr_oor;

    logic        rd_req;
    logic        wr_req;
    logic        both_req;
    logic        in_range;
    logic        commit;
    logic [15:0] rd_word;

    // Active-low lane enables: a disabled lane reads back as zero.
    function automatic logic [15:0] lane_mask(input logic [15:0] word,
                                              input logic ub, input logic lb);
        return {ub ? 8'h00 : word[15:8], lb ? 8'h00 : word[7:0]};
    endfunction

    assign rd_req     = !Mem_CE && !Mem_OE &&  Mem_WE;
    assign wr_req     = !Mem_CE && !Mem_WE &&  Mem_OE;
    assign both_req   = !Mem_CE && !Mem_OE && !Mem_WE;
    assign in_range   = (ADDR[19:8] == 12'd0);
    assign rd_word    = in_range ? lane_mask(mem[ADDR[7:0]], Mem_UB, Mem_LB) : 16'h0000;
    assign commit     = (state == WR1) && wr_req && !wr_oor;
    assign Data_valid = (state == RD);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            Data_out  <= 16'h0000;
            Range_err <= 1'b0;
            Conflict  <= 1'b0;
            Rd_count  <= 8'd0;
            Wr_count  <= 8'd0;
        end else begin
            Range_err <= 1'b0;
            if (both_req) begin
                Conflict <= 1'b1;
                state    <= IDLE;
                Data_out <= 16'h0000;
            end else begin
                case (state)
                    IDLE: begin
                        if (rd_req) begin
                            state     <= RD;
                            Data_out  <= rd_word;
                            Range_err <= !in_range;
                        end else if (wr_req) begin
                            state     <= WR1;
                            Range_err <= !in_range;
                        end
                    end
                    RD: begin
                        if (rd_req) begin
                            Data_out <= rd_word;
                        end else begin
                            state    <= IDLE;
                            Data_out <= 16'h0000;
                            Rd_count <= Rd_count + 8'd1;
                        end
                    end
                    WR1: begin
                        // Out-of-range writes still count; only the commit is suppressed.
                        if (wr_req) begin
                            state    <= WR_DONE;
                            Wr_count <= Wr_count + 8'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    WR_DONE: begin
                        if (Mem_CE || Mem_WE) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Write request captured on entry to WR1; only consumed from WR1.
    always_ff @(posedge Clk) begin
        if (state == IDLE && wr_req) begin
            wr_addr <= ADDR[7:0];
            wr_data <= Data_in;
            wr_ub   <= Mem_UB;
            wr_lb   <= Mem_LB;
            wr_oor  <= !in_range;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
        end else if (commit) begin
            if (!wr_ub) mem[wr_addr][15:8] <= wr_data[15:8];
            if (!wr_lb) mem[wr_addr][7:0]  <= wr_data[7:0];
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Table-driven write/read checks with a read-data scoreboard, plus hand
// sequences for conflict, reset-during-write and counter wrap.
module tb_mem_responder;
    logic        Clk = 1'b0;
    logic        Reset;
    logic [19:0] ADDR;
    logic [15:0] Data_in;
    logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
    logic [15:0] Data_out;
    logic        Data_valid, Range_err, Conflict;
    logic [7:0]  Rd_count, Wr_count;

    int total = 0;
    int bad   = 0;
    int rd_exp = 0;
    int wr_exp = 0;
    logic [15:0] sb_q[$];

    typedef struct {
        logic [19:0] addr;
        logic [15:0] wdata;
        logic        wub;
        logic        wlb;
        int          wcyc;
        logic        rub;
        logic        rlb;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[10];

    mem_responder dut (
        .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .Data_in(Data_in),
        .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .Data_out(Data_out), .Data_valid(Data_valid), .Range_err(Range_err),
        .Conflict(Conflict), .Rd_count(Rd_count), .Wr_count(Wr_count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (Reset === 1'b0 && Data_valid === 1'b1) begin
            if (sb_q.size() == 0) chk("sb_unexpected_valid", 32'(sb_q.size()), 32'd1);
            else chk("sb_read_data", 32'(Data_out), 32'(sb_q.pop_front()));
        end
    end

    task automatic bus_idle();
        Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1; Mem_UB = 1'b0; Mem_LB = 1'b0;
    endtask

    task automatic write_word(input logic [19:0] addr, input logic [15:0] data,
                              input logic ub, input logic lb, input int ncyc);
        @(negedge Clk);
        ADDR = addr; Data_in = data; Mem_UB = ub; Mem_LB = lb;
        Mem_CE = 1'b0; Mem_WE = 1'b0; Mem_OE = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge Clk);
            if (i == 0) chk("wr_range_err", 32'(Range_err), 32'(addr[19:8] != 12'd0));
        end
        bus_idle();
        @(negedge Clk);
        if (ncyc >= 2) wr_exp = (wr_exp + 1) % 256;
        chk("wr_count", 32'(Wr_count), 32'(wr_exp));
    endtask

    task automatic read_word(input logic [19:0] addr, input logic ub, input logic lb,
                             input int ncyc, input logic [15:0] exp);
        @(negedge Clk);
        ADDR = addr; Mem_UB = ub; Mem_LB = lb;
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1;
        for (int i = 0; i < ncyc; i++) sb_q.push_back(exp);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge Clk);
            if (i == 0) chk("rd_range_err", 32'(Range_err), 32'(addr[19:8] != 12'd0));
            if (i == 1) chk("rd_range_err_pulse", 32'(Range_err), 32'd0);
        end
        bus_idle();
        @(negedge Clk);
        rd_exp = (rd_exp + 1) % 256;
        chk("rd_count", 32'(Rd_count), 32'(rd_exp));
        chk("idle_data_out", 32'(Data_out), 32'd0);
        chk("idle_valid", 32'(Data_valid), 32'd0);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        vecs[0] = '{20'h00012, 16'hBEEF, 1'b0, 1'b0, 2, 1'b0, 1'b0, 16'hBEEF};
        vecs[1] = '{20'h00012, 16'h1234, 1'b1, 1'b0, 2, 1'b0, 1'b0, 16'hBE34};
        vecs[2] = '{20'h00012, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 1'b1, 16'hBE00};
        vecs[3] = '{20'h00012, 16'h0000, 1'b0, 1'b0, 0, 1'b1, 1'b0, 16'h0034};
        vecs[4] = '{20'h00005, 16'hAAAA, 1'b0, 1'b0, 1, 1'b0, 1'b0, 16'h0000};
        vecs[5] = '{20'h000FF, 16'h5A5A, 1'b0, 1'b1, 2, 1'b0, 1'b0, 16'h5A00};
        vecs[6] = '{20'h00100, 16'h5555, 1'b0, 1'b0, 2, 1'b0, 1'b0, 16'h0000};
        vecs[7] = '{20'h00000, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 1'b0, 16'h0000};
        vecs[8] = '{20'h00080, 16'hC3C3, 1'b0, 1'b0, 3, 1'b0, 1'b0, 16'hC3C3};
        vecs[9] = '{20'h00080, 16'h0000, 1'b0, 1'b0, 0, 1'b1, 1'b1, 16'h0000};

        Reset = 1'b0; ADDR = '0; Data_in = '0;
        bus_idle();
        #1 Reset = 1'b1;
        #2;
        chk("rst_data_out", 32'(Data_out), 32'd0);
        chk("rst_valid", 32'(Data_valid), 32'd0);
        chk("rst_range_err", 32'(Range_err), 32'd0);
        chk("rst_conflict", 32'(Conflict), 32'd0);
        chk("rst_rd_count", 32'(Rd_count), 32'd0);
        chk("rst_wr_count", 32'(Wr_count), 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].wcyc > 0)
                write_word(vecs[v].addr, vecs[v].wdata, vecs[v].wub, vecs[v].wlb, vecs[v].wcyc);
            read_word(vecs[v].addr, vecs[v].rub, vecs[v].rlb, 2, vecs[v].exp);
        end

        // Conflict from IDLE: sticky, no write, no valid.
        @(negedge Clk);
        ADDR = 20'h00012; Data_in = 16'hFFFF;
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b0;
        @(negedge Clk);
        chk("conflict_set", 32'(Conflict), 32'd1);
        chk("conflict_valid", 32'(Data_valid), 32'd0);
        @(negedge Clk);
        bus_idle();
        repeat (3) @(negedge Clk);
        chk("conflict_sticky", 32'(Conflict), 32'd1);
        read_word(20'h00012, 1'b0, 1'b0, 2, 16'hBE34);

        // Conflict while in RD drops the read immediately.
        @(negedge Clk);
        ADDR = 20'h00080; Mem_UB = 1'b0; Mem_LB = 1'b0;
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1;
        sb_q.push_back(16'hC3C3);
        @(negedge Clk);
        Mem_WE = 1'b0;
        @(negedge Clk);
        chk("conflict_rd_valid", 32'(Data_valid), 32'd0);
        chk("conflict_rd_data", 32'(Data_out), 32'd0);
        bus_idle();
        @(negedge Clk);

        // Reset arriving while in WR1.
        @(negedge Clk);
        ADDR = 20'h00033; Data_in = 16'h7777; Mem_UB = 1'b0; Mem_LB = 1'b0;
        Mem_CE = 1'b0; Mem_WE = 1'b0; Mem_OE = 1'b1;
        @(negedge Clk);
        #1 Reset = 1'b1;
        #1;
        chk("async_rst_conflict", 32'(Conflict), 32'd0);
        chk("async_rst_wr_count", 32'(Wr_count), 32'd0);
        chk("async_rst_rd_count", 32'(Rd_count), 32'd0);
        chk("async_rst_data_out", 32'(Data_out), 32'd0);
        @(negedge Clk);
        bus_idle();
        @(negedge Clk);
        sb_q.delete();
        rd_exp = 0; wr_exp = 0;

        // Request already present on the first edge after reset release.
        Reset = 1'b0;
        ADDR = 20'h00033; Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1;
        sb_q.push_back(16'h0000);
        @(negedge Clk);
        chk("post_rst_valid", 32'(Data_valid), 32'd1);
        bus_idle();
        @(negedge Clk);
        rd_exp = 1;
        chk("post_rst_rd_count", 32'(Rd_count), 32'd1);

        for (int i = 0; i < 255; i++) read_word(20'(i), 1'b0, 1'b0, 1, 16'h0000);
        chk("rd_count_wrap", 32'(Rd_count), 32'd0);

        read_word(20'h00012, 1'b0, 1'b0, 2, 16'h0000);
        read_word(20'h00033, 1'b0, 1'b0, 2, 16'h0000);
        chk("final_wr_count", 32'(Wr_count), 32'd0);
        chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
